// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

   localparam int unsigned XLEN_DEFAULT      = 64;
   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

   // Fetch sequencer states: START after reset, FETCH issues a request,
   // WAIT expects its response, HOLD parks a response while IF/ID is stalled,
   // DROP waits out a wrong-path response.
   typedef enum logic [2:0] {
      START = 3'd0,
      FETCH = 3'd1,
      WAIT  = 3'd2,
      HOLD  = 3'd3,
      DROP  = 3'd4
   } state_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry {pc, instr} buffer for a response that arrived while IF/ID was stalled.
module fetch_hold_buf #(
   parameter int unsigned XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic            clear,
   input  logic [XLEN-1:0] in_pc,
   input  logic [31:0]     in_instr,
   output logic            valid,
   output logic [XLEN-1:0] pc,
   output logic [31:0]     instr
);

   // Clear wins over load so a redirect always empties the entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid <= 1'b0;
         pc    <= '0;
         instr <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         pc    <= in_pc;
         instr <= in_instr;
      end
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: PC, one-outstanding imem requests, IF/ID slot, branch redirect.
module fetch_pc_unit
   import fetch_pkg::*;
#(
   parameter int unsigned      XLEN      = XLEN_DEFAULT,
   parameter logic [XLEN-1:0]  RESET_PC  = '0,
   parameter logic [31:0]      NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            is_branch,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   input  logic            stall,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   output logic            if_id_valid,
   output logic [XLEN-1:0] if_id_pc,
   output logic [31:0]     if_id_instr,
   output logic            flush_out
);

   state_t          state, state_n;
   logic [XLEN-1:0] pc, pc_n;
   logic [XLEN-1:0] req_pc, req_pc_n;
   logic            if_id_valid_n;
   logic [XLEN-1:0] if_id_pc_n;
   logic [31:0]     if_id_instr_n;
   logic            flush_n;

   logic            redirect;
   logic            handshake;
   logic            slot_free;
   logic            slot_load;
   logic            buf_load;
   logic            buf_clear;
   logic            buf_valid;
   logic [XLEN-1:0] buf_pc;
   logic [31:0]     buf_instr;

   assign redirect       = is_branch & branch_taken;
   assign slot_free      = ~if_id_valid | ~stall;
   assign imem_req_valid = (state == FETCH);
   assign handshake      = imem_req_valid & imem_req_ready;
   assign imem_addr      = pc;

   // Parking slot for a response that cannot enter IF/ID yet.
   fetch_hold_buf #(
      .XLEN (XLEN)
   ) u_hold_buf (
      .clk      (clk),
      .reset    (reset),
      .load     (buf_load),
      .clear    (buf_clear),
      .in_pc    (req_pc),
      .in_instr (imem_rsp_data),
      .valid    (buf_valid),
      .pc       (buf_pc),
      .instr    (buf_instr)
   );

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= START;
         pc          <= RESET_PC;
         req_pc      <= '0;
         if_id_valid <= 1'b0;
         if_id_pc    <= '0;
         if_id_instr <= NOP_INSTR;
         flush_out   <= 1'b0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         req_pc      <= req_pc_n;
         if_id_valid <= if_id_valid_n;
         if_id_pc    <= if_id_pc_n;
         if_id_instr <= if_id_instr_n;
         flush_out   <= flush_n;
      end
   end

   // Next-state and next-value logic; a taken branch overrides everything last.
   always_comb begin
      state_n       = state;
      pc_n          = pc;
      req_pc_n      = req_pc;
      if_id_valid_n = if_id_valid;
      if_id_pc_n    = if_id_pc;
      if_id_instr_n = if_id_instr;
      flush_n       = 1'b0;
      slot_load     = 1'b0;
      buf_load      = 1'b0;
      buf_clear     = 1'b0;

      case (state)
         START: state_n = FETCH;
         FETCH: begin
            if (handshake) begin
               req_pc_n = pc;
               pc_n     = pc + XLEN'(4);
               state_n  = WAIT;
            end
         end
         WAIT: begin
            if (imem_rsp_valid) begin
               if (slot_free) begin
                  slot_load     = 1'b1;
                  if_id_valid_n = 1'b1;
                  if_id_pc_n    = req_pc;
                  if_id_instr_n = imem_rsp_data;
                  state_n       = FETCH;
               end else begin
                  buf_load = 1'b1;
                  state_n  = HOLD;
               end
            end
         end
         HOLD: begin
            if (buf_valid && slot_free) begin
               slot_load     = 1'b1;
               if_id_valid_n = 1'b1;
               if_id_pc_n    = buf_pc;
               if_id_instr_n = buf_instr;
               buf_clear     = 1'b1;
               state_n       = FETCH;
            end
         end
         DROP: begin
            if (imem_rsp_valid) state_n = FETCH;
         end
         default: state_n = START;
      endcase

      // A draining IF/ID with nothing new behind it becomes a bubble.
      if (!slot_load && !stall) begin
         if_id_valid_n = 1'b0;
         if_id_instr_n = NOP_INSTR;
      end

      if (redirect) begin
         pc_n          = {branch_target[XLEN-1:2], 2'b00};
         if_id_valid_n = 1'b0;
         if_id_instr_n = NOP_INSTR;
         buf_load      = 1'b0;
         buf_clear     = 1'b1;
         flush_n       = 1'b1;
         // A request still in flight after this edge belongs to the wrong path.
         if (handshake ||
             (state == WAIT && !imem_rsp_valid) ||
             (state == DROP && !imem_rsp_valid))
            state_n = DROP;
         else
            state_n = FETCH;
      end
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: transaction-level model plus directed scenarios.
module tb_fetch_pc_unit;

   localparam logic [63:0] RST_PC = 64'h1000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        is_branch, branch_taken, stall;
   logic [63:0] branch_target;
   logic        imem_req_valid, imem_req_ready;
   logic [63:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        if_id_valid;
   logic [63:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic        flush_out;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          lat;
   logic        stray;

   fetch_pc_unit #(
      .XLEN      (64),
      .RESET_PC  (RST_PC),
      .NOP_INSTR (NOP)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .is_branch      (is_branch),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .stall          (stall),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .if_id_valid    (if_id_valid),
      .if_id_pc       (if_id_pc),
      .if_id_instr    (if_id_instr),
      .flush_out      (flush_out)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memword(input logic [63:0] a);
      return {16'hA5A5, a[15:0]};
   endfunction

   // Instruction memory: answers each accepted request after `lat` cycles.
   logic        pend;
   int          cnt;
   logic [63:0] paddr;
   always @(negedge clk) begin
      if (reset) begin
         pend           <= 1'b0;
         cnt            <= 0;
         paddr          <= '0;
         imem_rsp_valid <= 1'b0;
         imem_rsp_data  <= '0;
      end else begin
         imem_rsp_valid <= stray;
         imem_rsp_data  <= 32'hDEAD_BEEF;
         if (pend && cnt == 1) begin
            imem_rsp_valid <= 1'b1;
            imem_rsp_data  <= memword(paddr);
            pend           <= 1'b0;
         end else if (pend) begin
            cnt <= cnt - 1;
         end
         if (imem_req_valid && imem_req_ready) begin
            pend  <= 1'b1;
            cnt   <= lat;
            paddr <= imem_addr;
         end
      end
   end

   // Transaction-level model: next fetch pc, the one outstanding request
   // (marked wrong-path after a redirect), a parked response, and IF/ID.
   typedef struct packed {
      logic        start;
      logic [63:0] pc;
      logic        out;
      logic        wrong;
      logic [63:0] out_pc;
      logic        buf_v;
      logic [63:0] buf_pc;
      logic [31:0] buf_instr;
      logic        v;
      logic [63:0] ipc;
      logic [31:0] instr;
      logic        flush;
   } model_t;

   model_t m;

   function automatic model_t model_next(input model_t c, input logic br, input logic tk,
                                         input logic [63:0] tgt, input logic stl,
                                         input logic rdy, input logic rv,
                                         input logic [31:0] rd);
      model_t n      = c;
      logic   redir  = br & tk;
      logic   req    = !c.start && !c.out && !c.buf_v;
      logic   acc    = req && rdy;
      logic   slot   = !c.v || !stl;
      logic   loaded = 1'b0;
      n.flush = 1'b0;
      n.start = 1'b0;
      if (redir) begin
         n.out   = acc || (c.out && !rv);
         n.wrong = 1'b1;
         n.pc    = tgt & ~64'h3;
         n.v     = 1'b0;
         n.instr = NOP;
         n.buf_v = 1'b0;
         n.flush = 1'b1;
      end else begin
         if (c.out && rv) begin
            n.out = 1'b0;
            if (!c.wrong) begin
               if (slot) begin
                  n.v = 1'b1; n.ipc = c.out_pc; n.instr = rd; loaded = 1'b1;
               end else begin
                  n.buf_v = 1'b1; n.buf_pc = c.out_pc; n.buf_instr = rd;
               end
            end
         end else if (c.buf_v && slot) begin
            n.v = 1'b1; n.ipc = c.buf_pc; n.instr = c.buf_instr; n.buf_v = 1'b0; loaded = 1'b1;
         end
         if (acc) begin
            n.out = 1'b1; n.wrong = 1'b0; n.out_pc = c.pc; n.pc = c.pc + 64'd4;
         end
         if (!loaded && !stl) begin
            n.v = 1'b0; n.instr = NOP;
         end
      end
      return n;
   endfunction

   // Model state update, alongside the DUT.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m <= '{start: 1'b1, pc: RST_PC, out: 1'b0, wrong: 1'b0, out_pc: '0,
                buf_v: 1'b0, buf_pc: '0, buf_instr: '0, v: 1'b0, ipc: '0,
                instr: NOP, flush: 1'b0};
      end else begin
         m <= model_next(m, is_branch, branch_taken, branch_target, stall,
                         imem_req_ready, imem_rsp_valid, imem_rsp_data);
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every output against the model.
   task automatic check_model();
      chk("model req_valid", 64'(imem_req_valid), 64'(!m.start && !m.out && !m.buf_v));
      chk("model imem_addr", imem_addr, m.pc);
      chk("model if_id_valid", 64'(if_id_valid), 64'(m.v));
      if (m.v) chk("model if_id_pc", if_id_pc, m.ipc);
      chk("model if_id_instr", 64'(if_id_instr), 64'(m.instr));
      chk("model flush_out", 64'(flush_out), 64'(m.flush));
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         check_model();
      end
   endtask

   task automatic branch(input logic b, input logic t, input logic [63:0] tgt);
      is_branch     = b;
      branch_taken  = t;
      branch_target = tgt;
   endtask

   initial begin
      branch(1'b0, 1'b0, 64'h0);
      stall          = 1'b0;
      imem_req_ready = 1'b1;
      lat            = 1;
      stray          = 1'b0;
      #1 reset = 1'b1;
      step(2);
      chk("reset req_valid", 64'(imem_req_valid), 64'd0);
      chk("reset addr", imem_addr, 64'h1000);
      chk("reset if_id_pc", if_id_pc, 64'h0);
      chk("reset if_id_instr", 64'(if_id_instr), 64'h13);
      reset = 1'b0;

      // Straight-line fetch from RESET_PC.
      step(1);
      chk("t1 first req", 64'(imem_req_valid), 64'd1);
      chk("t1 addr0", imem_addr, 64'h1000);
      step(1);
      chk("t1 addr1", imem_addr, 64'h1004);
      step(1);
      chk("t1 ifid pc A", if_id_pc, 64'h1000);
      chk("t1 ifid instr A", 64'(if_id_instr), 64'hA5A5_1000);
      step(2);
      chk("t1 ifid pc B", if_id_pc, 64'h1004);
      chk("t1 ifid instr B", 64'(if_id_instr), 64'hA5A5_1004);
      chk("t1 addr2", imem_addr, 64'h1008);
      chk("t1 flush", 64'(flush_out), 64'd0);

      // Taken branch while waiting on 0x1008 (slow memory).
      lat = 3;
      step(1);
      branch(1'b1, 1'b1, 64'h2002);
      step(1);
      branch(1'b0, 1'b0, 64'h0);
      lat = 1;
      chk("t2 flush hi", 64'(flush_out), 64'd1);
      chk("t2 ifid invalid", 64'(if_id_valid), 64'd0);
      chk("t2 addr", imem_addr, 64'h2000);
      chk("t2 no req in drop", 64'(imem_req_valid), 64'd0);
      step(1);
      chk("t2 flush one cycle", 64'(flush_out), 64'd0);
      step(1);
      chk("t2 refetch req", 64'(imem_req_valid), 64'd1);
      chk("t2 refetch addr", imem_addr, 64'h2000);
      chk("t2 stale discarded", 64'(if_id_valid), 64'd0);

      // Not-taken branch has no effect.
      branch(1'b1, 1'b0, 64'h3000);
      step(2);
      chk("t3 ifid pc", if_id_pc, 64'h2000);
      chk("t3 addr", imem_addr, 64'h2004);
      chk("t3 flush", 64'(flush_out), 64'd0);
      branch(1'b0, 1'b0, 64'h0);

      // Redirect coincident with the response.
      step(1);
      branch(1'b1, 1'b1, 64'h4000);
      step(1);
      branch(1'b0, 1'b0, 64'h0);
      chk("t5 goes fetch", 64'(imem_req_valid), 64'd1);
      chk("t5 addr", imem_addr, 64'h4000);
      chk("t5 flush", 64'(flush_out), 64'd1);
      chk("t5 ifid invalid", 64'(if_id_valid), 64'd0);

      // Reset in the middle of a request, then a stray response.
      step(1);
      reset = 1'b1;
      #1;
      chk("t6 req_valid", 64'(imem_req_valid), 64'd0);
      chk("t6 addr", imem_addr, 64'h1000);
      chk("t6 ifid valid", 64'(if_id_valid), 64'd0);
      chk("t6 ifid instr", 64'(if_id_instr), 64'h13);
      step(2);
      reset = 1'b0;
      stray = 1'b1;
      step(1);
      stray = 1'b0;
      chk("t6 first req", 64'(imem_req_valid), 64'd1);
      chk("t6 first addr", imem_addr, 64'h1000);
      chk("t6 stray ignored", 64'(if_id_valid), 64'd0);

      // Stall with IF/ID holding 0x1004 as 0x1008 returns.
      step(4);
      chk("t4 ifid pc pre", if_id_pc, 64'h1004);
      stall = 1'b1;
      step(2);
      chk("t4 hold pc", if_id_pc, 64'h1004);
      chk("t4 hold instr", 64'(if_id_instr), 64'hA5A5_1004);
      chk("t4 no req", 64'(imem_req_valid), 64'd0);
      step(1);
      chk("t4 still held", if_id_pc, 64'h1004);
      stall = 1'b0;
      step(1);
      chk("t4 ifid pc", if_id_pc, 64'h1008);
      chk("t4 ifid instr", 64'(if_id_instr), 64'hA5A5_1008);
      chk("t4 next addr", imem_addr, 64'h100C);
      chk("t4 next req", 64'(imem_req_valid), 64'd1);

      // Memory not ready, redirect without and then with a handshake.
      imem_req_ready = 1'b0;
      step(2);
      chk("nr addr held", imem_addr, 64'h100C);
      branch(1'b1, 1'b1, 64'h5003);
      step(1);
      chk("nr redirect addr", imem_addr, 64'h5000);
      chk("nr redirect req", 64'(imem_req_valid), 64'd1);
      imem_req_ready = 1'b1;
      branch(1'b1, 1'b1, 64'h6000);
      step(1);
      branch(1'b0, 1'b0, 64'h0);
      chk("hs redirect drop", 64'(imem_req_valid), 64'd0);
      chk("hs redirect addr", imem_addr, 64'h6000);
      step(1);
      chk("hs drop done", 64'(imem_req_valid), 64'd1);
      branch(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
      step(1);
      branch(1'b0, 1'b0, 64'h0);
      chk("wrap target", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      step(2);
      chk("wrap pc", imem_addr, 64'h0);
      step(1);
      chk("wrap ifid pc", if_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap ifid instr", 64'(if_id_instr), 64'hA5A5_FFFC);
      step(6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
